// File: rtl/traffic_light_monitor_if.sv
// traffic_light_monitor_if: light-code inputs and decoded phase/violation outputs of the monitor.
interface traffic_light_monitor_if;
    logic        X;
    logic [2:0]  cntry;
    logic [2:0]  hghwy;
    logic [2:0]  phase;
    logic        err_pulse;
    logic [2:0]  err_code;
    logic        err_sticky;
    logic [15:0] cycle_cnt;
    modport master (output X, cntry, hghwy, input phase, err_pulse, err_code, err_sticky, cycle_cnt);
    modport slave  (input X, cntry, hghwy, output phase, err_pulse, err_code, err_sticky, cycle_cnt);
endinterface

// File: rtl/traffic_light_monitor.sv
// traffic_light_monitor: tracks the light phase sequence and flags code, pairing, ordering,
// dwell and sensor-timeout violations from registered light samples.
module traffic_light_monitor #(
    parameter int MIN_YEL    = 3,
    parameter int MIN_ALLRED = 2,
    parameter int X_TO       = 4
) (
    input logic clk,
    input logic rst,
    traffic_light_monitor_if.slave bus
);
    typedef enum logic [2:0] {HG = 3'd0, HY = 3'd1, AR = 3'd2, CG = 3'd3, CY = 3'd4, UNSYNC = 3'd7} phase_t;
    localparam logic [7:0] YEL_MIN = 8'(MIN_YEL);
    localparam logic [7:0] AR_MIN  = 8'(MIN_ALLRED);
    localparam logic [7:0] XTO_M1  = 8'(X_TO - 1);
    logic        x_r;
    logic [2:0]  c_r, h_r;
    phase_t      state, state_nxt, pair, succ;
    logic [7:0]  dwell, dwell_nxt, xcnt, xcnt_nxt;
    logic [2:0]  err, err_code;
    logic        err_pulse, err_sticky;
    logic [15:0] cycle_cnt;
    logic        bad_code, resync, synced, moved, x_run, cnt_inc;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= UNSYNC;
        else      state <= state_nxt;
    end

    always_comb begin
        bad_code = c_r > 3'd2 || h_r > 3'd2;
        pair = (c_r == 3'd0 && h_r == 3'd2) ? HG :
               (c_r == 3'd0 && h_r == 3'd1) ? HY :
               (c_r == 3'd0 && h_r == 3'd0) ? AR :
               (c_r == 3'd2 && h_r == 3'd0) ? CG :
               (c_r == 3'd1 && h_r == 3'd0) ? CY : UNSYNC;
        succ = state == HG ? HY : state == HY ? AR : state == AR ? CG : state == CG ? CY : HG;
        synced  = state != UNSYNC;
        resync  = pair == UNSYNC;
        moved   = synced && !resync && pair != state;
        x_run   = synced && !resync && pair == HG && x_r;
        cnt_inc = moved && state == CY && pair == HG;
        // priority chain: lowest code wins when several rules trip together
        err = bad_code ? 3'd1 :
              resync ? 3'd2 :
              moved && pair != succ ? 3'd3 :
              moved && (state == HY || state == CY) && dwell < YEL_MIN ? 3'd4 :
              moved && state == AR && dwell < AR_MIN ? 3'd5 :
              x_run && xcnt == XTO_M1 ? 3'd6 : 3'd0;
        state_nxt = resync ? UNSYNC : pair;
        dwell_nxt = resync ? 8'd0 : (moved || !synced) ? 8'd1 : dwell == 8'hFF ? dwell : dwell + 8'd1;
        xcnt_nxt  = !x_run ? 8'd0 : xcnt > XTO_M1 ? xcnt : xcnt + 8'd1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            x_r        <= 1'b0;
            c_r        <= 3'd0;
            h_r        <= 3'd0;
            dwell      <= 8'd0;
            xcnt       <= 8'd0;
            err_pulse  <= 1'b0;
            err_code   <= 3'd0;
            err_sticky <= 1'b0;
            cycle_cnt  <= 16'd0;
        end else begin
            x_r       <= bus.X;
            c_r       <= bus.cntry;
            h_r       <= bus.hghwy;
            dwell     <= dwell_nxt;
            xcnt      <= xcnt_nxt;
            err_pulse <= err != 3'd0;
            if (err != 3'd0) begin
                err_code   <= err;
                err_sticky <= 1'b1;
            end
            if (cnt_inc && cycle_cnt != 16'hFFFF) cycle_cnt <= cycle_cnt + 16'd1;
        end
    end

    assign bus.phase      = state;
    assign bus.err_pulse  = err_pulse;
    assign bus.err_code   = err_code;
    assign bus.err_sticky = err_sticky;
    assign bus.cycle_cnt  = cycle_cnt;
endmodule

// File: tb/tb_traffic_light_monitor.sv
// tb_traffic_light_monitor: directed vector table, corner sequences and randomized run
// against a cycle-level reference model of the light-sequence rules.
module tb_traffic_light_monitor;
    localparam int MIN_YEL = 3, MIN_ALLRED = 2, X_TO = 4;
    logic clk = 1'b0, rst = 1'b1;
    traffic_light_monitor_if bus();
    traffic_light_monitor #(.MIN_YEL(MIN_YEL), .MIN_ALLRED(MIN_ALLRED), .X_TO(X_TO)) dut (
        .clk(clk), .rst(rst), .bus(bus)
    );
    always #5 clk = ~clk;

    typedef struct {bit x; int c, h, ph, pulse, code, cnt;} vec_t;
    vec_t vq[$];
    int tests = 0, fails = 0;
    int lut[3][3];
    int cp[5] = '{0, 0, 0, 2, 1};
    int hp[5] = '{2, 1, 0, 0, 0};
    int m_ph, m_dw, m_xc, m_code, m_cnt, m_pulse, m_sticky, s_x, s_c, s_h;

    task automatic chk(string name, int act, int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic add(int n, int c, int h, int ph, int p, int code, int cnt);
        for (int i = 0; i < n; i++) vq.push_back('{1'b0, c, h, ph, (i == 0) ? p : 0, code, cnt});
    endtask

    task automatic drive(bit x, int c, int h);
        bus.X = x; bus.cntry = 3'(c); bus.hghwy = 3'(h);
    endtask

    task automatic cyc(bit x, int c, int h);
        drive(x, c, h);
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        drive(0, 0, 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        m_ph = 7; m_dw = 0; m_xc = 0; m_code = 0; m_cnt = 0; m_pulse = 0; m_sticky = 0;
        s_x = 0; s_c = 0; s_h = 0;
    endtask

    // consumes the sample currently held in the input stage; leaves the expected outputs
    task automatic model_step();
        int np, e;
        np = (s_c <= 2 && s_h <= 2) ? lut[s_c][s_h] : -1;
        e = (s_c > 2 || s_h > 2) ? 1 : (np < 0) ? 2 : 0;
        if (e != 0) begin
            m_ph = 7; m_dw = 0; m_xc = 0;
        end else if (m_ph == 7) begin
            m_ph = np; m_dw = 1; m_xc = 0;
        end else begin
            if (np != m_ph) begin
                if (np != (m_ph + 1) % 5) e = 3;
                else if ((m_ph == 1 || m_ph == 4) && m_dw < MIN_YEL) e = 4;
                else if (m_ph == 2 && m_dw < MIN_ALLRED) e = 5;
                if (m_ph == 4 && np == 0 && m_cnt < 65535) m_cnt++;
                m_ph = np; m_dw = 1;
            end else if (m_dw < 255) m_dw++;
            if (m_ph == 0 && s_x != 0) begin
                if (m_xc < X_TO) begin
                    m_xc++;
                    if (m_xc == X_TO && e == 0) e = 6;
                end
            end else m_xc = 0;
        end
        m_pulse = (e != 0);
        if (e != 0) begin m_code = e; m_sticky = 1; end
    endtask

    task automatic chk_vec(int j);
        tests++;
        if (int'(bus.phase) != vq[j].ph || int'(bus.err_pulse) != vq[j].pulse ||
            int'(bus.err_code) != vq[j].code || int'(bus.cycle_cnt) != vq[j].cnt) begin
            fails++;
            $display("FAIL vec[%0d]: got ph=%0d p=%0d code=%0d cnt=%0d expected ph=%0d p=%0d code=%0d cnt=%0d",
                     j, bus.phase, bus.err_pulse, bus.err_code, bus.cycle_cnt,
                     vq[j].ph, vq[j].pulse, vq[j].code, vq[j].cnt);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, r, gp, c, h;
        bit x;
        for (int i = 0; i < 3; i++) for (int j = 0; j < 3; j++) lut[i][j] = -1;
        for (int k = 0; k < 5; k++) lut[cp[k]][hp[k]] = k;
        // full legal cycle, short yellow, HG->CG skip, illegal code in CG
        add(1, 7, 0, 7, 1, 1, 0);
        add(5, 0, 2, 0, 0, 1, 0); add(3, 0, 1, 1, 0, 1, 0); add(2, 0, 0, 2, 0, 1, 0);
        add(4, 2, 0, 3, 0, 1, 0); add(3, 1, 0, 4, 0, 1, 0); add(2, 0, 2, 0, 0, 1, 1);
        add(2, 0, 1, 1, 0, 1, 1); add(2, 0, 0, 2, 1, 4, 1); add(1, 2, 0, 3, 0, 4, 1);
        add(3, 1, 0, 4, 0, 4, 1); add(2, 0, 2, 0, 0, 4, 2); add(3, 2, 0, 3, 1, 3, 2);
        add(3, 1, 0, 4, 0, 3, 2); add(2, 0, 2, 0, 0, 3, 3); add(3, 0, 1, 1, 0, 3, 3);
        add(2, 0, 0, 2, 0, 3, 3); add(1, 2, 0, 3, 0, 3, 3); add(1, 3, 0, 7, 1, 1, 3);
        add(2, 0, 2, 0, 0, 1, 3);

        do_reset();
        chk("reset.phase", bus.phase, 7);
        chk("reset.pulse", bus.err_pulse, 0);
        chk("reset.code", bus.err_code, 0);
        chk("reset.sticky", bus.err_sticky, 0);
        chk("reset.cnt", bus.cycle_cnt, 0);
        for (int i = 0; i < vq.size(); i++) begin
            cyc(vq[i].x, vq[i].c, vq[i].h);
            if (i > 0) chk_vec(i - 1);
        end
        @(posedge clk); #1;
        chk_vec(vq.size() - 1);
        chk("table.sticky", bus.err_sticky, 1);

        // X held in HG beyond timeout: single flag
        do_reset();
        cyc(0, 7, 0); cyc(0, 0, 2); cyc(0, 0, 2);
        n = 0;
        repeat (6) begin cyc(1, 0, 2); n += bus.err_pulse; end
        repeat (2) begin cyc(0, 0, 2); n += bus.err_pulse; end
        chk("xto.pulses", n, 1);
        chk("xto.code", bus.err_code, 6);
        // illegal pair in the would-be timeout cycle
        n = 0;
        repeat (3) begin cyc(1, 0, 2); n += bus.err_pulse; end
        cyc(1, 1, 1); n += bus.err_pulse;
        cyc(1, 0, 2); n += bus.err_pulse;
        chk("xto_pair.code", bus.err_code, 2);
        chk("xto_pair.phase", bus.phase, 7);
        chk("xto_pair.pulses", n, 1);

        // asynchronous reset in AR, then fresh sync
        do_reset();
        cyc(0, 7, 0); cyc(0, 0, 2);
        repeat (3) cyc(0, 0, 1);
        repeat (2) cyc(0, 0, 0);
        chk("ar.phase", bus.phase, 2);
        #2 rst = 1'b0;
        #1;
        chk("async.phase", bus.phase, 7);
        chk("async.code", bus.err_code, 0);
        chk("async.sticky", bus.err_sticky, 0);
        chk("async.pulse", bus.err_pulse, 0);
        chk("async.cnt", bus.cycle_cnt, 0);
        @(posedge clk); #1 rst = 1'b1;
        n = 0;
        repeat (3) begin cyc(0, 0, 0); n += bus.err_pulse; end
        repeat (2) begin cyc(0, 2, 0); n += bus.err_pulse; end
        chk("resync.phase", bus.phase, 3);
        chk("resync.pulses", n, 0);
        chk("resync.sticky", bus.err_sticky, 0);

        // randomized run against the reference model
        do_reset();
        gp = 2;
        for (int i = 0; i < 500; i++) begin
            r = $urandom_range(0, 99);
            if (r >= 70 && r < 88) gp = (gp + 1) % 5;
            else if (r >= 88 && r < 92) gp = $urandom_range(0, 4);
            c = cp[gp]; h = hp[gp];
            if (r >= 92 && r < 96) begin c = $urandom_range(1, 2); h = $urandom_range(1, 2); end
            else if (r >= 96) begin c = $urandom_range(3, 7); h = $urandom_range(0, 7); end
            x = ($urandom_range(0, 9) < 7);
            model_step();
            s_x = x; s_c = c; s_h = h;
            cyc(x, c, h);
            tests++;
            if (int'(bus.phase) != m_ph || int'(bus.err_pulse) != m_pulse || int'(bus.err_code) != m_code ||
                int'(bus.err_sticky) != m_sticky || int'(bus.cycle_cnt) != m_cnt) begin
                fails++;
                $display("FAIL rand[%0d]: got ph=%0d p=%0d code=%0d st=%0d cnt=%0d expected ph=%0d p=%0d code=%0d st=%0d cnt=%0d",
                         i, bus.phase, bus.err_pulse, bus.err_code, bus.err_sticky, bus.cycle_cnt,
                         m_ph, m_pulse, m_code, m_sticky, m_cnt);
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
